serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Bit counter must hold 0..WIDTH-1 and never shrink below one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      int unsigned w;
      w = $clog2(width + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder cell driven once per cycle by the serial adder.
module serial_adder_full_adder (
   input  logic Bit1,
   input  logic Bit2,
   input  logic Bit3,
   output logic Sum,
   output logic Carry
);

   assign Sum   = Bit1 ^ Bit2 ^ Bit3;
   assign Carry = (Bit1 & Bit2) | (Bit1 & Bit3) | (Bit2 & Bit3);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first through one full-adder cell with a registered carry.
// Result/CarryOut are only written on completion, so partial sums are never visible.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   input  logic             CarryIn,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             CarryOut
);

   localparam int unsigned    CntW    = cnt_width(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;

   logic              cell_sum;
   logic              cell_carry;
   logic [WIDTH:0]    acc_shift;

   serial_adder_full_adder u_full_adder (
      .Bit1  (a_q[0]),
      .Bit2  (b_q[0]),
      .Bit3  (carry_q),
      .Sum   (cell_sum),
      .Carry (cell_carry)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
   assign acc_shift = {cell_sum, acc_q};

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               a_d     = OperandA;
               b_d     = OperandB;
               carry_d = CarryIn;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            acc_d   = acc_shift[WIDTH:1];
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = cell_carry;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               result_d = acc_shift[WIDTH:1];
               cout_d   = cell_carry;
               state_d  = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
      end
   end

   assign Busy     = (state_q == StShift);
   assign Done     = (state_q == StDone);
   assign Result   = result_q;
   assign CarryOut = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] res;
      logic       cout;
   } vec_t;

   logic       clk;
   logic       rst;

   logic       start8;
   logic [7:0] a8, b8;
   logic       cin8;
   logic       busy8, done8, cout8;
   logic [7:0] res8;

   logic       start1;
   logic [0:0] a1, b1;
   logic       cin1;
   logic       busy1, done1, cout1;
   logic [0:0] res1;

   int n_cmp = 0;
   int n_bad = 0;

   serial_adder #(.WIDTH(8)) dut8 (
      .Clock    (clk),
      .Reset    (rst),
      .Start    (start8),
      .OperandA (a8),
      .OperandB (b8),
      .CarryIn  (cin8),
      .Busy     (busy8),
      .Done     (done8),
      .Result   (res8),
      .CarryOut (cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .Clock    (clk),
      .Reset    (rst),
      .Start    (start1),
      .OperandA (a1),
      .OperandB (b1),
      .CarryIn  (cin1),
      .Busy     (busy1),
      .Done     (done1),
      .Result   (res1),
      .CarryOut (cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One complete 8-bit add; returns with the DUT back in IDLE.
   task automatic run8(input vec_t v, input string tag);
      int done_t;
      int busy_cnt;
      a8 = v.a; b8 = v.b; cin8 = v.cin; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = ~v.a; b8 = 8'($urandom); cin8 = ~v.cin;
      done_t = -1;
      busy_cnt = 0;
      for (int t = 0; t < 20; t++) begin
         if (done8) begin
            done_t = t;
            break;
         end
         if (busy8) busy_cnt++;
         tick();
      end
      check($sformatf("%s done_cycle", tag), done_t, 8);
      check($sformatf("%s busy_cycles", tag), busy_cnt, 8);
      check($sformatf("%s result", tag), {24'd0, res8}, {24'd0, v.res});
      check($sformatf("%s carry_out", tag), {31'd0, cout8}, {31'd0, v.cout});
      tick();
      check($sformatf("%s done_single", tag), {31'd0, done8}, 32'd0);
   endtask

   vec_t       vecs[8];
   logic [1:0] exp1[8];

   initial begin
      int   done_t;
      int   ndone;
      int   last_t;
      int   overlap;
      vec_t held[3];

      vecs[0] = '{a: 8'h3C, b: 8'h5A, cin: 1'b0, res: 8'h96, cout: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, res: 8'h00, cout: 1'b1};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, res: 8'hFF, cout: 1'b1};
      vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, res: 8'h01, cout: 1'b0};
      vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, res: 8'h00, cout: 1'b1};
      vecs[5] = '{a: 8'h12, b: 8'h34, cin: 1'b1, res: 8'h47, cout: 1'b0};
      vecs[6] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, res: 8'h80, cout: 1'b0};
      vecs[7] = '{a: 8'hA5, b: 8'h5A, cin: 1'b0, res: 8'hFF, cout: 1'b0};
      exp1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      held[0] = '{a: 8'h10, b: 8'h20, cin: 1'b0, res: 8'h30, cout: 1'b0};
      held[1] = '{a: 8'hF0, b: 8'h20, cin: 1'b1, res: 8'h11, cout: 1'b1};
      held[2] = '{a: 8'h55, b: 8'hAA, cin: 1'b1, res: 8'h00, cout: 1'b1};

      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      tick();
      tick();
      check("reset outputs w8", {22'd0, busy8, done8, cout8, res8}, 32'd0);
      check("reset outputs w1", {28'd0, busy1, done1, cout1, res1}, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run8(vecs[i], $sformatf("vec%0d", i));

      // WIDTH=1 exhaustive
      for (int i = 0; i < 8; i++) begin
         logic [2:0] bits;
         bits = 3'(i);
         a1 = bits[2]; b1 = bits[1]; cin1 = bits[0]; start1 = 1'b1;
         tick();
         start1 = 1'b0;
         done_t = -1;
         for (int t = 0; t < 6; t++) begin
            if (done1) begin
               done_t = t;
               break;
            end
            tick();
         end
         check($sformatf("w1 combo%0d done_cycle", i), done_t, 1);
         check($sformatf("w1 combo%0d sum", i), {30'd0, cout1, res1}, {30'd0, exp1[i]});
         tick();
      end

      // Start pulses mid-add must be ignored
      a8 = 8'h21; b8 = 8'h43; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      ndone = 0;
      overlap = 0;
      for (int t = 0; t < 20; t++) begin
         if (t == 3 || t == 7) begin
            start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
         end else begin
            start8 = 1'b0;
         end
         if (done8) ndone++;
         if (done8 && busy8) overlap++;
         tick();
      end
      start8 = 1'b0;
      check("ignored_start done_count", ndone, 1);
      check("ignored_start busy_done_overlap", overlap, 0);
      check("ignored_start result", {23'd0, cout8, res8}, {23'd0, 1'b0, 8'h64});

      // Reset in the middle of an add
      a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int t = 0; t < 4; t++) tick();
      check("midadd result_stable", {24'd0, res8}, {24'd0, 8'h64});
      check("midadd busy", {31'd0, busy8}, 32'd1);
      rst = 1'b1;
      #1;
      check("async_reset outputs", {22'd0, busy8, done8, cout8, res8}, 32'd0);
      tick();
      rst = 1'b0;
      ndone = 0;
      for (int t = 0; t < 15; t++) begin
         if (done8) ndone++;
         tick();
      end
      check("after_reset no_done", ndone, 0);
      run8(vecs[0], "post_reset");

      // Start held high: back-to-back adds every WIDTH+2 cycles
      a8 = held[0].a; b8 = held[0].b; cin8 = held[0].cin; start8 = 1'b1;
      tick();
      ndone = 0;
      last_t = -1;
      for (int t = 0; t < 40; t++) begin
         if (t == 2) begin
            a8 = held[1].a; b8 = held[1].b; cin8 = held[1].cin;
         end
         if (t == 12) begin
            a8 = held[2].a; b8 = held[2].b; cin8 = held[2].cin;
         end
         if (t == 22) start8 = 1'b0;
         if (done8) begin
            if (ndone == 0) check("held first_done", t, 8);
            else check($sformatf("held spacing%0d", ndone), t - last_t, 10);
            if (ndone < 3) begin
               check($sformatf("held result%0d", ndone), {23'd0, cout8, res8},
                     {23'd0, held[ndone].cout, held[ndone].res});
            end
            ndone++;
            last_t = t;
         end
         tick();
      end
      check("held done_count", ndone, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
